// File: rtl/tanh_share_arbiter.sv
// Shares one fixed-latency Tanh unit among N_REQ requesters.
// Arbitration is round-robin per burst; a tag pipeline follows each in-flight
// word so its result returns to the requester that issued it.
module tanh_share_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned W        = 32,
    parameter int unsigned TANH_LAT = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tanh_en,
    output logic [W-1:0]       tanh_in,
    input  logic [W-1:0]       tanh_out,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_last,
    output logic               busy
);

    localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NST = TANH_LAT + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic          last;
    } tag_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    tag_t          tags [NST];

    logic [IW-1:0] win;
    logic          found;
    logic [IW-1:0] gidx;
    logic          accept;
    logic          acc_last;
    logic [W-1:0]  acc_data;
    logic          tag_any;

    // Round-robin search starting just after the last winner
    always_comb begin : rr_search
        int unsigned idx;
        idx   = 0;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req_valid[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Grant: owner while locked, otherwise the round-robin winner; nothing in reset
    always_comb begin
        req_ready = '0;
        if (rstn && en) begin
            if (state == LOCK) begin
                req_ready[owner] = 1'b1;
            end else if (found) begin
                req_ready[win] = 1'b1;
            end
        end
    end

    assign gidx     = (state == LOCK) ? owner : win;
    assign accept   = |(req_valid & req_ready);
    assign acc_last = req_last[gidx];
    assign acc_data = req_data[32'(gidx) * W +: W];

    // Any word still travelling through the Tanh unit
    always_comb begin
        tag_any = 1'b0;
        for (int unsigned s = 0; s < NST; s++) begin
            tag_any = tag_any | tags[s].v;
        end
    end

    assign tanh_en = accept | tag_any;
    assign busy    = (state == LOCK) | tag_any;

    // Burst FSM, issue register, tag pipeline and response register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= IW'(N_REQ - 1);
            tanh_in   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            for (int unsigned s = 0; s < NST; s++) begin
                tags[s] <= '0;
            end
        end else begin
            tags[0] <= accept ? {1'b1, gidx, acc_last} : '0;
            for (int unsigned s = 1; s < NST; s++) begin
                tags[s] <= tags[s-1];
            end

            if (accept) begin
                tanh_in <= acc_data;
                ptr     <= gidx;
                owner   <= gidx;
                state   <= acc_last ? IDLE : LOCK;
            end

            rsp_valid <= '0;
            rsp_last  <= tags[NST-1].v & tags[NST-1].last;
            if (tags[NST-1].v) begin
                rsp_valid[tags[NST-1].id] <= 1'b1;
                rsp_data                  <= tanh_out;
            end
        end
    end

endmodule

// File: tb/tb_tanh_share_arbiter.sv
// Bench for tanh_share_arbiter: directed vector table, reset-in-flight sequence
// and random traffic, all checked every cycle against a transaction-level model.
module tb_tanh_share_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;
    localparam int unsigned L = 2;
    localparam int unsigned R = 16;

    logic           clk;
    logic           rstn;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tanh_en;
    logic [W-1:0]   tanh_in;
    logic [W-1:0]   tanh_out;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_last;
    logic           busy;

    int n_chk;
    int n_fail;

    tanh_share_arbiter #(.N_REQ(N), .W(W), .TANH_LAT(L)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tanh_en(tanh_en), .tanh_in(tanh_in),
        .tanh_out(tanh_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in Tanh unit: an arbitrary bijection delayed by L enabled cycles
    function automatic logic [W-1:0] tanh_fn(input logic [W-1:0] x);
        return {x[15:0], ~x[31:16]} ^ 32'h1357_9bdf;
    endfunction

    logic [W-1:0] tpipe [L];
    always @(posedge clk) begin
        if (tanh_en) begin
            tpipe[0] <= tanh_fn(tanh_in);
            for (int j = 1; j < L; j++) tpipe[j] <= tpipe[j-1];
        end
    end
    assign tanh_out = tpipe[L-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [W-1:0] d);
        en        = e;
        req_valid = v;
        req_last  = l;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = d;
    endtask

    // Reference model: burst lock, round-robin pointer, and a schedule of results
    // keyed by the sampling cycle in which each result must be visible.
    int           cyc;
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    logic [W-1:0] m_tin;
    bit           sch_v    [R];
    int           sch_id   [R];
    bit           sch_last [R];
    logic [W-1:0] sch_data [R];

    initial begin
        cyc = 0; m_locked = 0; m_owner = 0; m_ptr = N - 1; m_tin = '0;
        for (int i = 0; i < R; i++) sch_v[i] = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_locked = 0; m_owner = 0; m_ptr = N - 1; m_tin = '0;
                for (int i = 0; i < R; i++) sch_v[i] = 0;
                chk("rst_req_ready", 64'(req_ready), 64'(0));
                chk("rst_tanh_en",   64'(tanh_en),   64'(0));
                chk("rst_tanh_in",   64'(tanh_in),   64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_rsp_data",  64'(rsp_data),  64'(0));
                chk("rst_rsp_last",  64'(rsp_last),  64'(0));
                chk("rst_busy",      64'(busy),      64'(0));
            end else begin
                int           slot;
                bit           infl;
                bit           acc;
                int           win;
                logic [N-1:0] exp_rv;
                logic [N-1:0] exp_rdy;
                slot   = cyc % R;
                exp_rv = '0;
                if (sch_v[slot]) exp_rv[sch_id[slot]] = 1'b1;
                chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
                chk("rsp_last",  64'(rsp_last),  64'(sch_v[slot] & sch_last[slot]));
                if (sch_v[slot]) chk("rsp_data", 64'(rsp_data), 64'(sch_data[slot]));
                sch_v[slot] = 0;

                infl = 0;
                for (int j = 1; j <= L + 1; j++) infl |= sch_v[(cyc + j) % R];
                chk("busy",    64'(busy),    64'(m_locked | infl));
                chk("tanh_in", 64'(tanh_in), 64'(m_tin));

                exp_rdy = '0;
                win     = -1;
                if (en) begin
                    if (m_locked) begin
                        win = m_owner;
                    end else begin
                        for (int k = 1; k <= N; k++) begin
                            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                        end
                    end
                    if (win >= 0) exp_rdy[win] = 1'b1;
                end
                chk("req_ready", 64'(req_ready), 64'(exp_rdy));
                acc = |(req_valid & exp_rdy);
                chk("tanh_en", 64'(tanh_en), 64'(acc | infl));

                if (acc) begin
                    slot           = (cyc + L + 2) % R;
                    m_tin          = req_data[win*W +: W];
                    sch_v[slot]    = 1;
                    sch_id[slot]   = win;
                    sch_last[slot] = req_last[win];
                    sch_data[slot] = tanh_fn(m_tin);
                    m_ptr          = win;
                    m_owner        = win;
                    m_locked       = !req_last[win];
                end
            end
            cyc++;
        end
    end

    typedef struct {
        logic         en;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [W-1:0] d;
        logic [N-1:0] rdy;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic e, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [W-1:0] d, input logic [N-1:0] rdy, input int rep);
        vec_t t;
        t.en = e; t.v = v; t.l = l; t.d = d; t.rdy = rdy;
        for (int i = 0; i < rep; i++) tbl.push_back(t);
    endtask

    initial begin
        bit rst_active;
        n_chk = 0; n_fail = 0;
        rstn = 1'b1;
        drive(1'b0, '0, '0, '0);
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // round-robin: requesters 0 and 2 with single-word bursts
        add(1, 4'b0101, 4'b0101, 32'h0101_0000, 4'b0001, 1);
        add(1, 4'b0101, 4'b0101, 32'h0202_0000, 4'b0100, 1);
        add(1, 4'b0101, 4'b0101, 32'h0303_0000, 4'b0001, 1);
        add(1, 4'b0101, 4'b0101, 32'h0404_0000, 4'b0100, 1);
        // lone word from requester 0, then drain
        add(1, 4'b0001, 4'b0001, 32'h0000_0000, 4'b0001, 1);
        add(1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4);
        // burst lock: requester 1 three words while requester 0 waits
        add(1, 4'b0011, 4'b0001, 32'hff94_0000, 4'b0010, 1);
        add(1, 4'b0011, 4'b0001, 32'h7c5a_0000, 4'b0010, 1);
        add(1, 4'b0011, 4'b0011, 32'h0000_0000, 4'b0010, 1);
        add(1, 4'b0001, 4'b0001, 32'h5555_0000, 4'b0001, 1);
        // enable gating inside a 2-word burst from requester 2
        add(1, 4'b0100, 4'b0000, 32'h1111_0000, 4'b0100, 1);
        add(0, 4'b0101, 4'b0100, 32'h2222_0000, 4'b0000, 5);
        add(1, 4'b0101, 4'b0100, 32'h2222_0000, 4'b0100, 1);
        add(1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1);
        // owner stalls inside lock while requester 0 is valid
        add(1, 4'b1000, 4'b0000, 32'h3333_0000, 4'b1000, 1);
        add(1, 4'b0001, 4'b0001, 32'h0000_0000, 4'b1000, 4);
        add(1, 4'b1001, 4'b1001, 32'h4444_0000, 4'b1000, 1);
        add(1, 4'b0001, 4'b0001, 32'h6666_0000, 4'b0001, 1);
        add(1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 drive(tbl[i].en, tbl[i].v, tbl[i].l, tbl[i].d);
            #1 chk("tbl_ready", 64'(req_ready), 64'(tbl[i].rdy));
        end

        // reset while two words of a burst are in flight
        @(posedge clk); #1 drive(1, 4'b0010, 4'b0000, 32'haaaa_0000);
        @(posedge clk); #1 drive(1, 4'b0010, 4'b0000, 32'hbbbb_0000);
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        chk("mid_rst_ready",     64'(req_ready), 64'(0));
        chk("mid_rst_tanh_en",   64'(tanh_en),   64'(0));
        chk("mid_rst_tanh_in",   64'(tanh_in),   64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_busy",      64'(busy),      64'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        drive(1, 4'b0000, 4'b0000, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk); #1 drive(1, 4'b0101, 4'b0101, 32'h7777_0000);
        #1 chk("post_rst_first_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1 drive(1, 4'b0000, 4'b0000, 32'h0);
        repeat (5) @(posedge clk);

        // random traffic with occasional resets
        rst_active = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rst_active) begin
                rstn = 1'b1; rst_active = 0;
            end else if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0; rst_active = 1;
            end
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = ($urandom_range(0, 9) < 6);
                req_last[i]        = ($urandom_range(0, 9) < 3);
                req_data[i*W +: W] = $urandom;
            end
        end
        @(posedge clk); #1 rstn = 1'b1;
        drive(1, 4'b0000, 4'b0000, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
